// File: rtl/imem_port_arbiter.sv
// Shares one instruction-memory port between IF-stage fetches and the loader.
// Optional conflict-cycle statistics counter enabled by `define ARB_STATS_EN.
module imem_port_arbiter #(
  parameter int WORD_LEN     = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int MAX_LD_BURST = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                IF_REQ,
  input  logic [WORD_LEN-1:0] IF_ADDR,
  output logic [WORD_LEN-1:0] IF_RDATA,
  output logic                IF_VALID,
  output logic                IF_FREEZE,
  input  logic                LD_REQ,
  input  logic [WORD_LEN-1:0] LD_ADDR,
  input  logic [WORD_LEN-1:0] LD_WDATA,
  output logic                LD_ACK,
  output logic                MEM_EN,
  output logic                MEM_WE,
  output logic [WORD_LEN-1:0] MEM_ADDR,
  output logic [WORD_LEN-1:0] MEM_WDATA,
  input  logic [WORD_LEN-1:0] MEM_RDATA
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]         STAT_CONFLICT
`endif
);

  localparam int CW = $clog2(MEM_LATENCY + 1);
  localparam int BW = $clog2(MAX_LD_BURST + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  state_t        state_nxt;
  logic          owner_ld;
  logic [CW-1:0] cnt;
  logic [BW-1:0] burst;

  logic                any_req;
  logic                ld_win;
  logic                done;
  logic [WORD_LEN-1:0] grant_addr;
  logic                unused_addr_bits;

  assign any_req = IF_REQ | LD_REQ;
  assign ld_win  = LD_REQ &
                   (~IF_REQ | (burst < BW'(MAX_LD_BURST)));
  assign done    = (state == BUSY) && (cnt == CW'(1));

  assign unused_addr_bits = ^{IF_ADDR[1:0], LD_ADDR[1:0]};

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req) state_nxt = BUSY;
      BUSY:    if (done)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / grant decode
  always_comb begin
    IF_FREEZE  = IF_REQ & ~IF_VALID;
    grant_addr = ld_win ? LD_ADDR : IF_ADDR;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      MEM_EN    <= 1'b0;
      MEM_WE    <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_WDATA <= '0;
      IF_RDATA  <= '0;
      IF_VALID  <= 1'b0;
      LD_ACK    <= 1'b0;
      owner_ld  <= 1'b0;
      cnt       <= '0;
      burst     <= '0;
    end else begin
      MEM_EN   <= 1'b0;
      IF_VALID <= 1'b0;
      LD_ACK   <= 1'b0;
      if (state == IDLE) begin
        if (any_req) begin
          MEM_EN   <= 1'b1;
          MEM_WE   <= ld_win;
          MEM_ADDR <= {grant_addr[WORD_LEN-1:2], 2'b00};
          if (ld_win) MEM_WDATA <= LD_WDATA;
          owner_ld <= ld_win;
          cnt      <= CW'(MEM_LATENCY);
        end
        // A loader win under IF pressure implies burst is below the cap
        if (!IF_REQ || !ld_win) burst <= '0;
        else                    burst <= burst + BW'(1);
      end else begin
        cnt <= cnt - CW'(1);
        if (done) begin
          if (owner_ld) begin
            LD_ACK <= 1'b1;
          end else begin
            IF_VALID <= 1'b1;
            IF_RDATA <= MEM_RDATA;
          end
        end
      end
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)
      STAT_CONFLICT <= '0;
    else if (IF_REQ && owner_ld && state == BUSY)
      STAT_CONFLICT <= STAT_CONFLICT + 16'd1;
  end
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a small word-addressed memory.
// Checks reset, fetch timing, loader bursts, arbitration order and drops.
module tb_imem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        if_freeze;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic [31:0] ld_wdata;
  logic        ld_ack;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
`ifdef ARB_STATS_EN
  logic [15:0] stat_conflict;
`endif

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [0:63];
  logic [31:0] rd_addr;

  imem_port_arbiter #(
    .WORD_LEN(32),
    .MEM_LATENCY(2),
    .MAX_LD_BURST(4)
  ) dut (
    .CLK(clk),
    .RESET(rst_n),
    .IF_REQ(if_req),
    .IF_ADDR(if_addr),
    .IF_RDATA(if_rdata),
    .IF_VALID(if_valid),
    .IF_FREEZE(if_freeze),
    .LD_REQ(ld_req),
    .LD_ADDR(ld_addr),
    .LD_WDATA(ld_wdata),
    .LD_ACK(ld_ack),
    .MEM_EN(mem_en),
    .MEM_WE(mem_we),
    .MEM_ADDR(mem_addr),
    .MEM_WDATA(mem_wdata),
    .MEM_RDATA(mem_rdata)
`ifdef ARB_STATS_EN
    ,
    .STAT_CONFLICT(stat_conflict)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
    mem[4]  <= 32'hDEAD_BEEF;
    rd_addr <= 32'h0;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
      rd_addr <= mem_addr;
    end
  end

  assign mem_rdata = mem[rd_addr[7:2]];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  int          n_ev;
  int          n_ack;
  int          n_grant;
  int          first_g;
  int          last_g;
  int          widx;
  int          bad_frz;
  int          ld_grants;
  logic [9:0]  order;

  initial begin
    rst_n    = 1'b0;
    if_req   = 1'b0;
    if_addr  = 32'h0;
    ld_req   = 1'b0;
    ld_addr  = 32'h0;
    ld_wdata = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_mem_en", mem_en, 0);
    check("rst_if_valid", if_valid, 0);
    check("rst_ld_ack", ld_ack, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_freeze", if_freeze, 0);
    rst_n = 1'b1;

    // reset while a fetch is in flight
    @(negedge clk);
    if_req  = 1'b1;
    if_addr = 32'h20;
    @(negedge clk);
    check("t1_grant", mem_en, 1);
    rst_n = 1'b0;
    #1;
    check("t1_rst_en", mem_en, 0);
    check("t1_rst_addr", mem_addr, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    if_req = 1'b0;
    n_ev = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (if_valid || mem_en) n_ev++;
    end
    check("t1_no_valid", n_ev, 0);

    // lone fetch
    if_req  = 1'b1;
    if_addr = 32'h0000_0013;
    @(negedge clk);
    check("t2_c1_en", mem_en, 1);
    check("t2_c1_we", mem_we, 0);
    check("t2_c1_addr", mem_addr, 32'h10);
    check("t2_c1_frz", if_freeze, 1);
    check("t2_c1_vld", if_valid, 0);
    @(negedge clk);
    check("t2_c2_en", mem_en, 0);
    check("t2_c2_vld", if_valid, 0);
    check("t2_c2_frz", if_freeze, 1);
    @(negedge clk);
    check("t2_c3_vld", if_valid, 1);
    check("t2_c3_data", if_rdata, 32'hDEAD_BEEF);
    check("t2_c3_frz", if_freeze, 0);
    if_req = 1'b0;
    @(negedge clk);
    check("t2_c4_vld", if_valid, 0);
    check("t2_c4_en", mem_en, 0);
    check("t2_hold", if_rdata, 32'hDEAD_BEEF);

    // loader burst of 8 words
    widx     = 0;
    n_ack    = 0;
    n_grant  = 0;
    first_g  = -1;
    last_g   = -1;
    ld_req   = 1'b1;
    ld_addr  = 32'h0;
    ld_wdata = 32'hA000_0000;
    for (int c = 0; c < 100 && widx < 8; c++) begin
      @(negedge clk);
      if (mem_en) begin
        n_grant++;
        if (first_g < 0) first_g = c;
        last_g = c;
      end
      if (ld_ack) begin
        n_ack++;
        widx++;
        if (widx == 8) begin
          ld_req = 1'b0;
        end else begin
          ld_addr  = 32'(widx * 4);
          ld_wdata = 32'hA000_0000 + 32'(widx * 32'h11);
        end
      end
    end
    ld_req = 1'b0;
    check("t3_acks", n_ack, 8);
    check("t3_grants", n_grant, 8);
    check("t3_spacing", last_g - first_g, 21);
    @(negedge clk);
    for (int i = 0; i < 8; i++)
      check($sformatf("t3_mem%0d", i), mem[i],
            32'hA000_0000 + 32'(i * 32'h11));

    // both requesters held continuously
    if_req    = 1'b1;
    if_addr   = 32'h10;
    ld_req    = 1'b1;
    ld_addr   = 32'h30;
    ld_wdata  = 32'h1234_5678;
    n_grant   = 0;
    bad_frz   = 0;
    ld_grants = 0;
    order     = '0;
    for (int c = 0; c < 60 && n_grant < 10; c++) begin
      @(negedge clk);
      if (if_freeze !== !if_valid) bad_frz++;
      if (mem_en) begin
        order = {order[8:0], mem_we};
        n_grant++;
        if (mem_we) ld_grants++;
      end
    end
    if_req = 1'b0;
    ld_req = 1'b0;
    check("t4_ngrant", n_grant, 10);
    check("t4_order", {22'h0, order}, {22'h0, 10'b1111011110});
    check("t4_freeze", bad_frz, 0);
    repeat (4) @(negedge clk);
`ifdef ARB_STATS_EN
    check("t6_stat", {16'h0, stat_conflict}, 32'(2 * ld_grants));
`endif

    // loader drops its request right after the grant
    ld_req   = 1'b1;
    ld_addr  = 32'h38;
    ld_wdata = 32'h5555_AAAA;
    @(negedge clk);
    check("t5_grant", mem_en & mem_we, 1);
    ld_req  = 1'b0;
    n_ack   = 0;
    n_grant = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ld_ack) n_ack++;
      if (mem_en) n_grant++;
    end
    check("t5_ack", n_ack, 1);
    check("t5_regrant", n_grant, 0);
    check("t5_mem", mem[14], 32'h5555_AAAA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
